pc_16: RTL

16-bit program counter for the Hack-style CPU datapath. It evaluates the 3-bit jump field of a C-instruction against the ALU status flags and picks the next instruction address: reset, jump target, increment, or hold. Its registered output is the instruction-memory address. The jump target comes from the A register, the same 16-bit value the A/M operand mux stage selects from.

---
 rtl/pc_16.sv | 48 ++++
 1 files changed

// File: rtl/pc_16.sv
// pc_16: Hack-style 16-bit program counter with jump evaluation.
// Picks reset, jump target, increment or hold at each rising edge.
module pc_16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        c_instr,
  input  logic [2:0]  jmp,
  input  logic        zr,
  input  logic        ng,
  input  logic        inc,
  output logic        taken,
  output logic [15:0] out,
  output logic        jumped
);

  logic [15:0] out_q, out_d;
  logic        jumped_q, jumped_d;
  logic        pos;

  assign pos   = ~ng & ~zr;
  assign taken = c_instr & ((jmp[2] & ng)
                          | (jmp[1] & zr)
                          | (jmp[0] & pos));

  // Reset beats jump beats increment; a jump ignores a stall.
  always_comb begin
    out_d    = out_q;
    jumped_d = 1'b0;
    if (reset) begin
      out_d = 16'h0000;
    end else if (taken) begin
      out_d    = in;
      jumped_d = 1'b1;
    end else if (inc) begin
      out_d = out_q + 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    out_q    <= out_d;
    jumped_q <= jumped_d;
  end

  assign out    = out_q;
  assign jumped = jumped_q;

endmodule
